regfile_sb: RTL and testbench

Parametrised register file with a producer scoreboard, write-to-read bypass and a sequenced clear, succeeding the fixed 32×32 two-read/one-write register file in the processor datapath. Storage is an array without per-entry reset, so it can map to distributed RAM. Reset or a clear request starts a sweep FSM that zeroes one entry per cycle. Per-register pending bits let the issue stage stall on operands whose producer has not yet written back.

---
 rtl/regfile_sb.sv | 159 +++++++++++++++
 tb/tb_regfile_sb.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a producer scoreboard,
// write-to-read bypass and a sequenced one-entry-per-cycle clear.
//
// Ports:
//   iClk, iRst          clock (rising edge), synchronous active-high reset
//   iClear              request a re-initialisation sweep (honoured in READY)
//   oReady              file initialised and accepting operations
//   iAddrA/B, oRegA/B   two combinational read ports
//   oBusyA/B            addressed register has an outstanding producer
//   iWrite/iAddrC/iRegC write-back port
//   iReserve/iAddrR     mark a register pending (instruction issued)
module regfile_sb #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned ZERO_R0 = 1,
    parameter int unsigned BYPASS  = 1
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iClear,
    output logic              oReady,
    input  logic [ADDR_W-1:0] iAddrA,
    input  logic [ADDR_W-1:0] iAddrB,
    output logic [DATA_W-1:0] oRegA,
    output logic [DATA_W-1:0] oRegB,
    output logic              oBusyA,
    output logic              oBusyB,
    input  logic              iWrite,
    input  logic [ADDR_W-1:0] iAddrC,
    input  logic [DATA_W-1:0] iRegC,
    input  logic              iReserve,
    input  logic [ADDR_W-1:0] iAddrR
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     ptr_q, ptr_d;
    logic [DEPTH-1:0]    pend_q, pend_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic                ready;
    logic                wr_valid;
    logic                rsv_valid;
    logic                zero_a, zero_b;

    assign ready  = (state_q == S_READY);
    assign oReady = ready;

    // Strobes only count in READY, and are dropped by a concurrent clear/reset.
    assign wr_valid  = ready && iWrite && !iClear && !iRst &&
                       ((iAddrC != '0) || (ZERO_R0 == 0));
    assign rsv_valid = ready && iReserve && !iClear && !iRst &&
                       ((iAddrR != '0) || (ZERO_R0 == 0));

    assign zero_a = (ZERO_R0 != 0) && (iAddrA == '0);
    assign zero_b = (ZERO_R0 != 0) && (iAddrB == '0);

    // Next-state: sweep pointer, pending bits and the single memory write port.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        pend_d    = pend_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q[ADDR_W-1:0];
        mem_wdata = '0;
        case (state_q)
            S_CLEAR: begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + (ADDR_W+1)'(1);
                if (ptr_q == LAST_PTR) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (iClear) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                    pend_d  = '0;
                end else begin
                    if (wr_valid) begin
                        mem_we            = 1'b1;
                        mem_waddr         = iAddrC;
                        mem_wdata         = iRegC;
                        pend_d[iAddrC]    = 1'b0;
                    end
                    // Applied after the write so a new producer wins.
                    if (rsv_valid) begin
                        pend_d[iAddrR] = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_CLEAR;
                ptr_d   = '0;
                pend_d  = '0;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
        end
    end

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge iClk) begin
        if (mem_we && !iRst) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Read port A.
    always_comb begin
        oRegA  = '0;
        oBusyA = 1'b0;
        if (ready && !zero_a) begin
            if ((BYPASS != 0) && wr_valid && (iAddrC == iAddrA)) begin
                oRegA = iRegC;
            end else begin
                oRegA  = mem_q[iAddrA];
                oBusyA = pend_q[iAddrA];
            end
        end
    end

    // Read port B.
    always_comb begin
        oRegB  = '0;
        oBusyB = 1'b0;
        if (ready && !zero_b) begin
            if ((BYPASS != 0) && wr_valid && (iAddrC == iAddrB)) begin
                oRegB = iRegC;
            end else begin
                oRegB  = mem_q[iAddrB];
                oBusyB = pend_q[iAddrB];
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one BYPASS=1 and one BYPASS=0 instance share the
// same stimulus and are compared every cycle against an abstract model.
module tb_regfile_sb;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        write = 1'b0;
    logic        reserve = 1'b0;
    logic [4:0]  addr_a = '0, addr_b = '0, addr_c = '0, addr_r = '0;
    logic [31:0] reg_c = '0;

    logic        rdy1, ba1, bb1, rdy0, ba0, bb0;
    logic [31:0] ra1, rb1, ra0, rb0;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1), .BYPASS(1)) u_byp (
        .iClk(clk), .iRst(rst), .iClear(clear), .oReady(rdy1),
        .iAddrA(addr_a), .iAddrB(addr_b), .oRegA(ra1), .oRegB(rb1),
        .oBusyA(ba1), .oBusyB(bb1), .iWrite(write), .iAddrC(addr_c),
        .iRegC(reg_c), .iReserve(reserve), .iAddrR(addr_r)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1), .BYPASS(0)) u_nb (
        .iClk(clk), .iRst(rst), .iClear(clear), .oReady(rdy0),
        .iAddrA(addr_a), .iAddrB(addr_b), .oRegA(ra0), .oRegB(rb0),
        .oBusyA(ba0), .oBusyB(bb0), .iWrite(write), .iAddrC(addr_c),
        .iRegC(reg_c), .iReserve(reserve), .iAddrR(addr_r)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [DEPTH];
    bit          m_pend [DEPTH];
    bit          m_ready = 1'b0;
    int          m_cnt = 0;
    bit          armed = 1'b0;

    function automatic logic [31:0] exp_reg(input logic [4:0] a, input bit byp, input bit wr_ok);
        if (!m_ready || a == 5'd0) return 32'd0;
        if (byp && wr_ok && addr_c == a) return reg_c;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp, input bit wr_ok);
        if (!m_ready || a == 5'd0) return 1'b0;
        if (byp && wr_ok && addr_c == a) return 1'b0;
        return m_pend[a];
    endfunction

    // Compare outputs, then advance the model to the upcoming rising edge.
    always @(negedge clk) begin
        bit wr_ok;
        wr_ok = m_ready && write && !clear && !rst && (addr_c != 5'd0);
        if (armed) begin
            chk("ready_byp", rdy1, m_ready);
            chk("ready_nb",  rdy0, m_ready);
            chk("rega_byp",  ra1, exp_reg(addr_a, 1'b1, wr_ok));
            chk("regb_byp",  rb1, exp_reg(addr_b, 1'b1, wr_ok));
            chk("rega_nb",   ra0, exp_reg(addr_a, 1'b0, wr_ok));
            chk("regb_nb",   rb0, exp_reg(addr_b, 1'b0, wr_ok));
            chk("busya_byp", ba1, exp_busy(addr_a, 1'b1, wr_ok));
            chk("busyb_byp", bb1, exp_busy(addr_b, 1'b1, wr_ok));
            chk("busya_nb",  ba0, exp_busy(addr_a, 1'b0, wr_ok));
            chk("busyb_nb",  bb0, exp_busy(addr_b, 1'b0, wr_ok));
        end
        if (rst || (m_ready && clear)) begin
            m_ready = 1'b0;
            m_cnt   = DEPTH;
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]  = 32'd0;
                m_pend[i] = 1'b0;
            end
            if (rst) armed = 1'b1;
        end else if (!m_ready) begin
            m_cnt--;
            if (m_cnt == 0) m_ready = 1'b1;
        end else begin
            if (wr_ok) begin
                m_mem[addr_c]  = reg_c;
                m_pend[addr_c] = 1'b0;
            end
            if (reserve && addr_r != 5'd0) m_pend[addr_r] = 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        clear = 1'b0; write = 1'b0; reserve = 1'b0;
    endtask

    // Called right after the edge that sampled rst/clear; counts edges to oReady.
    task automatic count_ready(input string nm);
        int n;
        n = 0;
        settle();
        chk({nm, "_low"}, rdy1, 1'b0);
        while (!rdy1 && n < 40) begin
            next();
            n++;
            settle();
        end
        chk({nm, "_edges"}, n, 32);
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        // Initial reset and sweep.
        rst = 1'b1;
        next();
        next();
        rst = 1'b0;
        count_ready("init");

        // Fill with garbage, then reset and restart mid-sweep at ptr=17.
        for (int i = 0; i < 40; i++) begin
            next();
            write = 1'b1; addr_c = 5'($urandom_range(0, 31)); reg_c = $urandom;
            reserve = 1'b1; addr_r = 5'($urandom_range(0, 31));
        end
        next();
        idle();
        rst = 1'b1;
        next();
        rst = 1'b0;
        repeat (17) next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        count_ready("restart");
        for (int i = 0; i < DEPTH; i++) begin
            next();
            addr_a = 5'(i); addr_b = 5'(DEPTH - 1 - i);
            settle();
            chk("swept_zero", ra1 | rb1 | ra0 | rb0, 32'd0);
        end

        // Write with bypass versus without.
        next();
        write = 1'b1; addr_c = 5'd5; reg_c = 32'hDEADBEEF; addr_a = 5'd5;
        settle();
        chk("byp_same_cycle", ra1, 32'hDEADBEEF);
        chk("nb_same_cycle",  ra0, 32'd0);
        next();
        write = 1'b0; addr_a = 5'd0; addr_b = 5'd5;
        settle();
        chk("byp_next_cycle", rb1, 32'hDEADBEEF);
        chk("nb_next_cycle",  rb0, 32'hDEADBEEF);
        next();
        write = 1'b1; addr_c = 5'd0; reg_c = 32'h1234; addr_a = 5'd0;
        settle();
        chk("r0_write", ra1, 32'd0);

        // Scoreboard on r7.
        next();
        write = 1'b0; reserve = 1'b1; addr_r = 5'd7; addr_a = 5'd7;
        settle();
        chk("rsv_same_cycle", ba1, 1'b0);
        next();
        reserve = 1'b0;
        settle();
        chk("rsv_busy_byp", ba1, 1'b1);
        chk("rsv_busy_nb",  ba0, 1'b1);
        next();
        write = 1'b1; addr_c = 5'd7; reg_c = 32'h12;
        settle();
        chk("wb_busy_byp", ba1, 1'b0);
        chk("wb_data_byp", ra1, 32'h12);
        chk("wb_busy_nb",  ba0, 1'b1);
        chk("wb_data_nb",  ra0, 32'd0);
        next();
        write = 1'b0;
        settle();
        chk("wb_after_nb_busy", ba0, 1'b0);
        chk("wb_after_nb_data", ra0, 32'h12);
        next();
        reserve = 1'b1; addr_r = 5'd0; addr_a = 5'd0;
        next();
        reserve = 1'b0;
        settle();
        chk("rsv_r0", ba1, 1'b0);

        // Write and reserve to the same pending register.
        next();
        reserve = 1'b1; addr_r = 5'd9;
        next();
        write = 1'b1; addr_c = 5'd9; reg_c = 32'hABC; addr_a = 5'd9;
        next();
        idle();
        settle();
        chk("wr_rsv_busy", ba1, 1'b1);
        chk("wr_rsv_data", ra1, 32'hABC);

        // Reserve r3 and write r4 together.
        next();
        reserve = 1'b1; addr_r = 5'd3; write = 1'b1; addr_c = 5'd4; reg_c = 32'h44;
        next();
        idle(); addr_a = 5'd3; addr_b = 5'd4;
        settle();
        chk("rsv3_busy", ba1, 1'b1);
        chk("wr4_busy",  bb1, 1'b0);
        chk("wr4_data",  rb1, 32'h44);

        // Clear with a concurrent write that must be dropped.
        next();
        clear = 1'b1; write = 1'b1; addr_c = 5'd2; reg_c = 32'h55; addr_a = 5'd2;
        settle();
        chk("clear_ready_still", rdy1, 1'b1);
        next();
        idle();
        count_ready("clear");
        addr_a = 5'd2; addr_b = 5'd9;
        settle();
        chk("clear_r2", ra1, 32'd0);
        chk("clear_busy_a", ba1, 1'b0);
        chk("clear_busy_b", bb1, 1'b0);

        // Randomised traffic, including rare clears and resets.
        for (int i = 0; i < 3000; i++) begin
            next();
            rst     = ($urandom_range(0, 499) == 0);
            clear   = ($urandom_range(0, 149) == 0);
            write   = !rst && ($urandom_range(0, 1) == 1);
            reserve = ($urandom_range(0, 9) < 4);
            addr_a  = rnd_addr();
            addr_b  = rnd_addr();
            addr_c  = rnd_addr();
            addr_r  = rnd_addr();
            reg_c   = $urandom;
        end
        next();
        rst = 1'b0;
        idle();
        for (int i = 0; i < 80 && !rdy1; i++) next();
        settle();
        chk("final_ready", rdy1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
